// File: rtl/if_id_stage_if.sv
// Fetch/decode bus of the IF/ID stage: instruction memory, EX branch resolution,
// ID/EX hazard inputs and the IF/ID register outputs.
interface if_id_stage_if;
  logic [31:0] Instr_In;
  logic        BranchTaken_In;
  logic [31:0] BranchTarget_In;
  logic [1:0]  IDEX_Mem2RegSEL_In;
  logic [4:0]  IDEX_RTAddr_In;
  logic [31:0] PCAddr_Out;
  logic [31:0] Instr_Out;
  logic [31:0] PCAddr_ID_Out;
  logic        Bubble_Out;
  logic        Done_Out;
  logic [31:0] CycleCount_Out;

  modport master (
    input  Instr_In, BranchTaken_In, BranchTarget_In, IDEX_Mem2RegSEL_In, IDEX_RTAddr_In,
    output PCAddr_Out, Instr_Out, PCAddr_ID_Out, Bubble_Out, Done_Out, CycleCount_Out
  );

  modport slave (
    output Instr_In, BranchTaken_In, BranchTarget_In, IDEX_Mem2RegSEL_In, IDEX_RTAddr_In,
    input  PCAddr_Out, Instr_Out, PCAddr_ID_Out, Bubble_Out, Done_Out, CycleCount_Out
  );
endinterface

// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID register: owns the PC, handles load-use stalls, EX branch
// flushes, and the halt drain that ends in a sticky Done_Out.
module if_id_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic           CLOCK,
  input logic           RESET,
  if_id_stage_if.master bus
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [7:0]  drain_q, drain_d;
  logic [31:0] cycle_q, cycle_d;
  logic        done_q, done_d;
  logic        bubble;

  logic [4:0] rs, rt;
  logic       stall, halt_id;

  assign rs      = instr_q[25:21];
  assign rt      = instr_q[20:16];
  assign stall   = (bus.IDEX_Mem2RegSEL_In == 2'b01) && (bus.IDEX_RTAddr_In != 5'd0) &&
                   ((bus.IDEX_RTAddr_In == rs) || (bus.IDEX_RTAddr_In == rt));
  assign halt_id = (instr_q == HALT_INSTR);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc_id_d = pc_id_q;
    drain_d = drain_q;
    done_d  = done_q;
    bubble  = 1'b0;
    unique case (state_q)
      StRun: begin
        // Branch outranks stall and halt so a wrong-path halt is squashed.
        if (bus.BranchTaken_In) begin
          pc_d    = bus.BranchTarget_In;
          instr_d = 32'h0;
          bubble  = 1'b1;
        end else if (stall) begin
          bubble = 1'b1;
        end else if (halt_id) begin
          instr_d = 32'h0;
          bubble  = 1'b1;
          state_d = StDrain;
          drain_d = 8'(DRAIN_CYCLES);
        end else begin
          instr_d = bus.Instr_In;
          pc_d    = pc_q + 32'd4;
          pc_id_d = pc_q + 32'd4;
        end
      end
      StDrain: begin
        drain_d = drain_q - 8'd1;
        if (drain_q <= 8'd1) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: ;
      default: state_d = StRun;
    endcase
    cycle_d = (state_q != StDone) ? cycle_q + 32'd1 : cycle_q;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc_id_q <= 32'h0;
      drain_q <= 8'd0;
      cycle_q <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc_id_q <= pc_id_d;
      drain_q <= drain_d;
      cycle_q <= cycle_d;
      done_q  <= done_d;
    end
  end

  assign bus.PCAddr_Out     = pc_q;
  assign bus.Instr_Out      = instr_q;
  assign bus.PCAddr_ID_Out  = pc_id_q;
  assign bus.Bubble_Out     = bubble & ~RESET;
  assign bus.Done_Out       = done_q;
  assign bus.CycleCount_Out = cycle_q;

endmodule
